// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared drain FSM state encoding and default FIFO depth
package uart_pkg;

    localparam int DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STB  = 2'd1,
        HOLD = 2'd2
    } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO storage with wrapping pointers and occupancy count
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

    // Full is judged on registered occupancy, so a same-cycle pop never admits a write.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_txfifo.sv
// rtl/uart_txfifo.sv - UART transmit FIFO with IDLE/STB/HOLD drain FSM; UART_TXFIFO_OVF_EN adds sticky overflow flag
module uart_txfifo #(
    parameter int DEPTH = uart_pkg::DEPTH_DEFAULT
) (
    input  logic                   SYSCLK,
    input  logic                   RESET_N,
    input  logic [7:0]             wrData,
    input  logic                   wrStb,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             txData,
    output logic                   txStb,
    input  logic                   txRdy
`ifdef UART_TXFIFO_OVF_EN
    ,
    output logic                   ovf,
    input  logic                   ovfClr
`endif
);

    import uart_pkg::*;

    drain_state_e state_q, state_d;
    logic         hold_first_q, hold_first_d;
    logic [7:0]   txdata_q, txdata_d;
    logic [7:0]   fifo_rd_data;
    logic         pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (SYSCLK),
        .rst_n   (RESET_N),
        .wr_data (wrData),
        .wr_en   (wrStb),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign txStb  = (state_q == STB);
    assign txData = txdata_q;

    // The UART drops txRdy one cycle late, so the first HOLD cycle must not trust it.
    always_comb begin
        state_d      = state_q;
        hold_first_d = 1'b0;
        txdata_d     = txdata_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && txRdy) begin
                    state_d  = STB;
                    pop      = 1'b1;
                    txdata_d = fifo_rd_data;
                end
            end
            STB: begin
                state_d      = HOLD;
                hold_first_d = 1'b1;
            end
            HOLD: begin
                if (!hold_first_q && txRdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            hold_first_q <= 1'b0;
            txdata_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            hold_first_q <= hold_first_d;
            txdata_q     <= txdata_d;
        end
    end

`ifdef UART_TXFIFO_OVF_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = (ovf_q && !ovfClr) || (wrStb && full);
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/uart_txfifo.md
UART_TXFIFO -- requirements
Module: uart_txfifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, range 2..256.
REQ-002 SHALL have port SYSCLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wrData  input  8  byte from host to queue.
REQ-005 SHALL have port wrStb  input  1  write strobe, one SYSCLK per byte.
REQ-006 SHALL have port full  output  1  high when count==DEPTH.
REQ-007 SHALL have port empty  output  1  high when count==0.
REQ-008 SHALL have port count  output  $clog2(DEPTH)+1  bytes currently queued.
REQ-009 SHALL have port txData  output  8  byte presented to downstream UART transmitter.
REQ-010 SHALL have port txStb  output  1  one-SYSCLK strobe qualifying txData.
REQ-011 SHALL have port txRdy  input  1  UART transmitter ready, high when it accepts a byte.

Function
REQ-012 SHALL store wrData at write pointer when wrStb=1 and full=0; write pointer increments modulo DEPTH.
REQ-013 SHALL discard wrStb when full=0 is false, with storage, pointers and count unchanged.
REQ-014 SHALL evaluate full from registered state before any same-cycle pop: a write while full is dropped even if a pop occurs that cycle.
REQ-015 SHALL update count as +1 on write only, -1 on pop only, unchanged on simultaneous write and pop; full, empty and count registered-consistent in every cycle.
REQ-016 SHALL run drain FSM with states IDLE, STB, HOLD.
REQ-017 IDLE -> STB when empty=0 and txRdy=1; on this transition, txData loaded from read pointer entry and read pointer increments modulo DEPTH (pop).
REQ-018 STB -> HOLD unconditionally; txStb=1 exactly and only while in STB.
REQ-019 HOLD -> IDLE when txRdy=1; the HOLD state SHALL ignore txRdy in its first cycle (UART deasserts txRdy one cycle after strobe).
REQ-020 SHALL hold txData stable from load until the next load.
REQ-021 Minimum strobe spacing SHALL be 3 SYSCLK; back-to-back bytes leave no idle bit time beyond what the UART imposes.
REQ-022 A write into an empty FIFO SHALL make empty=0 the next cycle; earliest txStb is 2 cycles after wrStb.
REQ-023 txRdy low in IDLE SHALL keep the FSM in IDLE with no pop.

Reset
REQ-024 RESET_N=0 SHALL immediately force: pointers 0, count 0, empty 1, full 0, state IDLE, txStb 0, txData 8'h00, ovf 0.
REQ-025 Reset mid-drain SHALL discard all queued bytes; any byte already strobed completes in the UART independently.
REQ-026 Storage array contents need not be reset.

Configuration
REQ-027 Macro UART_TXFIFO_OVF_EN defined: SHALL add ports ovf output 1 (sticky, set on any dropped write per REQ-013) and ovfClr input 1 (clears ovf next cycle; set wins over simultaneous clear).
REQ-028 Macro UART_TXFIFO_OVF_EN undefined: ovf/ovfClr ports and logic SHALL be absent; drops silent.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state enum (IDLE, STB, HOLD) and default DEPTH constant.
REQ-030 Storage and pointer/count logic SHALL be one sub-module sync_fifo (parameterised DEPTH, width 8); drain FSM lives in uart_txfifo.

Verification
REQ-031 Reset release, single wrStb with 8'h41, txRdy=1 -> txStb pulse 2 cycles later with txData=8'h41, empty=1 afterward.
REQ-032 16 writes 8'h00..8'h0F with txRdy=0 -> full=1, count=16; 17th write 8'hFF dropped, ovf=1 (macro on); then txRdy driven by UART model -> bytes 00..0F emitted in order, FF never.
REQ-033 Simultaneous wrStb and pop at count=5 -> count stays 5, order preserved.
REQ-034 Pointer wrap: 40 bytes streamed through DEPTH=16 with random txRdy gaps -> output sequence equals input, txStb spacing >=3 cycles.
REQ-035 RESET_N asserted with count=7 mid-HOLD -> outputs at reset values asynchronously; after release, empty=1, no txStb without new writes.
REQ-036 Connected to uart transmitter at BAUD=9600, XTAL=100 MHz, send "OK" -> serial line shows 8N1 frames 0x4F, 0x4B back-to-back.
